request_queues: RTL

REQUEST_QUEUES -- requirements
Module: request_queues

---
 rtl/memoredf_pkg.sv | 17 +
 rtl/queue_fifo.sv | 63 ++++++
 rtl/request_queues.sv | 104 ++++++++++
 3 files changed

// File: rtl/memoredf_pkg.sv
// Shared defaults and types for the request queues and the scheduler that
// arbitrates between them.
package memoredf_pkg;

   localparam int DEFAULT_NUMBER_OF_QUEUES = 4;
   localparam int DEFAULT_QUEUE_DEPTH      = 8;
   localparam int DEFAULT_DATA_WIDTH       = 64;
   localparam int QUEUE_ID_WIDTH           = $clog2(DEFAULT_NUMBER_OF_QUEUES);

   typedef logic [QUEUE_ID_WIDTH-1:0] queue_id_t;

   // An occupancy counter must be able to hold the value QUEUE_DEPTH itself.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/queue_fifo.sv
// Single circular FIFO holding the pending requests of one master.
module queue_fifo
   import memoredf_pkg::*;
#(
   parameter int QUEUE_DEPTH  = DEFAULT_QUEUE_DEPTH,
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   localparam int COUNT_WIDTH   = count_width(QUEUE_DEPTH),
   localparam int POINTER_WIDTH = $clog2(QUEUE_DEPTH)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DATA_WIDTH-1:0]  push_data,
   output logic [DATA_WIDTH-1:0]  head,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   full,
   output logic                   empty
);

   localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(QUEUE_DEPTH);

   logic [DATA_WIDTH-1:0]    storage [QUEUE_DEPTH];
   logic [POINTER_WIDTH-1:0] write_pointer;
   logic [POINTER_WIDTH-1:0] read_pointer;
   logic                     do_push;
   logic                     do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = storage[read_pointer];

   // Storage is left unreset: an entry is only ever read after it was written.
   always_ff @(posedge clock) begin
      if (do_push) begin
         storage[write_pointer] <= push_data;
      end
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         write_pointer <= '0;
         read_pointer  <= '0;
         count         <= '0;
      end else begin
         if (do_push) begin
            write_pointer <= write_pointer + POINTER_WIDTH'(1);
         end
         if (do_pop) begin
            read_pointer <= read_pointer + POINTER_WIDTH'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + COUNT_WIDTH'(1);
            2'b01:   count <= count - COUNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/request_queues.sv
// Per-master request queues feeding one registered dispatch port; the external
// scheduler picks which queue's head goes out next.
module request_queues
   import memoredf_pkg::*;
#(
   parameter int NUMBER_OF_QUEUES = DEFAULT_NUMBER_OF_QUEUES,
   parameter int QUEUE_DEPTH      = DEFAULT_QUEUE_DEPTH,
   parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
   localparam int COUNT_WIDTH     = count_width(QUEUE_DEPTH),
   localparam int ID_WIDTH        = $clog2(NUMBER_OF_QUEUES)
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic [NUMBER_OF_QUEUES-1:0]                 in_valid,
   input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0] in_data,
   output logic [NUMBER_OF_QUEUES-1:0]                 in_ready,
   output logic [NUMBER_OF_QUEUES-1:0]                 empty,
   output logic [NUMBER_OF_QUEUES-1:0][COUNT_WIDTH-1:0] occupancy,
   input  logic                                        sched_valid,
   input  logic [ID_WIDTH-1:0]                         sched_selection,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [DATA_WIDTH-1:0]                       out_data,
   output logic [ID_WIDTH-1:0]                         out_id,
   output logic                                        dispatched,
   output logic [ID_WIDTH-1:0]                         dispatched_id,
   output logic                                        sched_miss
);

   logic [NUMBER_OF_QUEUES-1:0]                 queue_full;
   logic [NUMBER_OF_QUEUES-1:0]                 queue_push;
   logic [NUMBER_OF_QUEUES-1:0]                 queue_pop;
   logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0] queue_head;
   logic                                        output_free;
   logic                                        selected_empty;
   logic [DATA_WIDTH-1:0]                       selected_head;
   logic                                        accept;
   logic                                        miss;

   for (genvar i = 0; i < NUMBER_OF_QUEUES; i++) begin : g_queue
      localparam logic [ID_WIDTH-1:0] THIS_ID = ID_WIDTH'(i);

      assign in_ready[i]   = ~queue_full[i] & ~reset;
      assign queue_push[i] = in_valid[i] & in_ready[i];
      assign queue_pop[i]  = accept & (sched_selection == THIS_ID);

      queue_fifo #(
         .QUEUE_DEPTH (QUEUE_DEPTH),
         .DATA_WIDTH  (DATA_WIDTH)
      ) u_queue_fifo (
         .clock     (clock),
         .reset     (reset),
         .push      (queue_push[i]),
         .pop       (queue_pop[i]),
         .push_data (in_data[i]),
         .head      (queue_head[i]),
         .count     (occupancy[i]),
         .full      (queue_full[i]),
         .empty     (empty[i])
      );
   end

   // An index with no matching queue reads as empty, so out-of-range grants
   // fall into the same miss path as grants to a drained queue.
   always_comb begin
      selected_empty = 1'b1;
      selected_head  = '0;
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
         if (sched_selection == ID_WIDTH'(i)) begin
            selected_empty = empty[i];
            selected_head  = queue_head[i];
         end
      end
   end

   assign output_free = ~out_valid | out_ready;
   assign accept      = sched_valid & output_free & ~selected_empty;
   assign miss        = sched_valid & output_free & selected_empty;

   // While stalled the output register and its id are frozen; once the
   // consumer takes the request without a replacement, only out_valid drops.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_id        <= '0;
         dispatched    <= 1'b0;
         dispatched_id <= '0;
         sched_miss    <= 1'b0;
      end else begin
         dispatched <= accept;
         sched_miss <= miss;
         if (accept) begin
            out_valid     <= 1'b1;
            out_data      <= selected_head;
            out_id        <= sched_selection;
            dispatched_id <= sched_selection;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
